cordic_arbiter: RTL

Shares the single CORDIC `pipeline` between two requesters. Channel A issues rotation jobs (angle in, cos/sin out); channel B issues vectoring/arctan jobs (x,y in, angle/magnitude out). The block arbitrates round-robin and drives the pipeline inputs. It tracks every in-flight job with a tag shift register matched to the pipeline latency, and steers each result back to its owner with a one-cycle valid pulse.

---
 rtl/cordic_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one CORDIC pipeline between rotation and vectoring requesters
module cordic_arbiter #(
   parameter int                    DATA_WIDTH      = 16,
   parameter int                    SECTOR_WIDTH    = 2,
   parameter int                    PIPE_LATENCY    = 10,
   parameter int                    MAX_OUTSTANDING = 4,
   parameter logic [DATA_WIDTH-1:0] A_X_INIT        = 16'h0100
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [DATA_WIDTH-1:0]   a_degree,
   input  logic [SECTOR_WIDTH-1:0] a_sector,

   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [DATA_WIDTH-1:0]   b_x,
   input  logic [DATA_WIDTH-1:0]   b_y,
   input  logic [SECTOR_WIDTH-1:0] b_sector,

   output logic [DATA_WIDTH-1:0]   pipe_degree_in,
   output logic [DATA_WIDTH-1:0]   pipe_x_in,
   output logic [DATA_WIDTH-1:0]   pipe_y_in,
   output logic [SECTOR_WIDTH-1:0] pipe_sector_in,
   output logic                    pipe_arctan_en_in,

   input  logic [DATA_WIDTH-1:0]   pipe_degree_out,
   input  logic [DATA_WIDTH-1:0]   pipe_x_out,
   input  logic [DATA_WIDTH-1:0]   pipe_y_out,
   input  logic [SECTOR_WIDTH-1:0] pipe_sector_out,
   input  logic                    pipe_arctan_en_out,

   output logic                    rsp_a_valid,
   output logic                    rsp_b_valid,
   output logic [DATA_WIDTH-1:0]   rsp_degree,
   output logic [DATA_WIDTH-1:0]   rsp_x,
   output logic [DATA_WIDTH-1:0]   rsp_y,
   output logic [SECTOR_WIDTH-1:0] rsp_sector,

   output logic                    busy,
   output logic                    tag_err
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   // Channel ids double as the expected arctan_en value of a returning job.
   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   logic [CNT_W-1:0]        cnt_a;
   logic [CNT_W-1:0]        cnt_b;
   logic                    last_grant;

   // in_tag travels with the pipe_*_in registers; tag[] then mirrors the
   // pipeline stages, so tag[PIPE_LATENCY-1] marks the cycle in which the
   // matching pipe_*_out value is present.
   logic                    in_tag_valid;
   logic                    in_tag_id;
   logic [PIPE_LATENCY-1:0] tag_valid;
   logic [PIPE_LATENCY-1:0] tag_id;

   logic elig_a;
   logic elig_b;
   logic grant_a;
   logic grant_b;
   logic retire;
   logic retire_a;
   logic retire_b;

   assign elig_a = a_valid && (cnt_a < CNT_MAX);
   assign elig_b = b_valid && (cnt_b < CNT_MAX);

   // Round-robin grant: a tie goes to the channel not served last.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (elig_a && elig_b) begin
         if (last_grant == ID_B) begin
            grant_a = 1'b1;
         end else begin
            grant_b = 1'b1;
         end
      end else begin
         grant_a = elig_a;
         grant_b = elig_b;
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   assign retire   = tag_valid[PIPE_LATENCY-1];
   assign retire_a = retire && (tag_id[PIPE_LATENCY-1] == ID_A);
   assign retire_b = retire && (tag_id[PIPE_LATENCY-1] == ID_B);

   assign busy = in_tag_valid || (|tag_valid) || (cnt_a != '0) || (cnt_b != '0);

   // Pipeline input registers: load the granted job, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_degree_in    <= '0;
         pipe_x_in         <= '0;
         pipe_y_in         <= '0;
         pipe_sector_in    <= '0;
         pipe_arctan_en_in <= 1'b0;
      end else if (grant_a) begin
         pipe_degree_in    <= a_degree;
         pipe_x_in         <= A_X_INIT;
         pipe_y_in         <= '0;
         pipe_sector_in    <= a_sector;
         pipe_arctan_en_in <= 1'b0;
      end else if (grant_b) begin
         pipe_degree_in    <= '0;
         pipe_x_in         <= b_x;
         pipe_y_in         <= b_y;
         pipe_sector_in    <= b_sector;
         pipe_arctan_en_in <= 1'b1;
      end
   end

   // Tag shift register: never stalls, an empty slot enters on idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_tag_valid <= 1'b0;
         in_tag_id    <= ID_A;
         tag_valid    <= '0;
         tag_id       <= '0;
      end else begin
         in_tag_valid <= grant_a || grant_b;
         in_tag_id    <= grant_b ? ID_B : ID_A;
         tag_valid[0] <= in_tag_valid;
         tag_id[0]    <= in_tag_id;
         for (int i = 1; i < PIPE_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
         end
      end
   end

   // Remember the winner of the most recent issue for tie-breaking.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= ID_B;
      end else if (grant_a) begin
         last_grant <= ID_A;
      end else if (grant_b) begin
         last_grant <= ID_B;
      end
   end

   // Per-channel in-flight counters; issue and retire together cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         case ({grant_a, retire_a})
            2'b10:   cnt_a <= cnt_a + CNT_W'(1);
            2'b01:   cnt_a <= cnt_a - CNT_W'(1);
            default: cnt_a <= cnt_a;
         endcase
         case ({grant_b, retire_b})
            2'b10:   cnt_b <= cnt_b + CNT_W'(1);
            2'b01:   cnt_b <= cnt_b - CNT_W'(1);
            default: cnt_b <= cnt_b;
         endcase
      end
   end

   // Capture the retiring pipeline result and pulse its owner's valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_a_valid <= 1'b0;
         rsp_b_valid <= 1'b0;
         rsp_degree  <= '0;
         rsp_x       <= '0;
         rsp_y       <= '0;
         rsp_sector  <= '0;
      end else begin
         rsp_a_valid <= retire_a;
         rsp_b_valid <= retire_b;
         if (retire) begin
            rsp_degree <= pipe_degree_out;
            rsp_x      <= pipe_x_out;
            rsp_y      <= pipe_y_out;
            rsp_sector <= pipe_sector_out;
         end
      end
   end

   // Sticky flag: a returning job whose mode bit disagrees with its owner.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_err <= 1'b0;
      end else if (retire && (pipe_arctan_en_out != tag_id[PIPE_LATENCY-1])) begin
         tag_err <= 1'b1;
      end
   end

endmodule
